float_normalizer: RTL and testbench

- Sequential consumer of the complement adder's raw sum. Takes sign, pre-shift exponent, 24-bit magnitude and the carry/shift flag.
- Normalizes the magnitude:
  - right shift once on carry-out;
  - otherwise left shift, one bit per cycle, until the hidden bit is set.
- Adjusts the exponent to match and packs an IEEE-754 single-precision word. Mantissa is truncated, not rounded.
- Sits at the back end of the floating adder. Valid/ready handshake on both sides.

---
 rtl/float_normalizer_pkg.sv | 27 ++
 rtl/float_normalizer_if.sv | 33 +++
 rtl/float_normalizer.sv | 124 ++++++++++++
 tb/tb_float_normalizer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/float_normalizer_pkg.sv
// Shared constants, state encoding and IEEE-754 single-precision packing helper
// for the floating-point adder back end.
package float_normalizer_pkg;

    localparam int FP_EXP_W  = 8;
    localparam int FP_MANT_W = 24;
    localparam int FP_CNT_W  = 5;

    localparam logic [FP_EXP_W-1:0] EXP_MAX = '1;
    localparam int                  BIAS    = 127;

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        DONE
    } state_t;

    // Drops the hidden bit; the fraction is truncated, never rounded.
    function automatic logic [FP_EXP_W+FP_MANT_W-1:0] pack(
        input logic                 sign,
        input logic [FP_EXP_W-1:0]  exp,
        input logic [FP_MANT_W-1:0] mant
    );
        return {sign, exp, mant[FP_MANT_W-2:0]};
    endfunction

endpackage

// File: rtl/float_normalizer_if.sv
// Operand/result handshake bundle between the complement adder, the normalizer
// and the downstream result consumer.
interface float_normalizer_if #(
    parameter int EXP_W  = 8,
    parameter int MANT_W = 24,
    parameter int CNT_W  = 5
);
    logic                    i_valid;
    logic                    o_in_ready;
    logic                    i_sign;
    logic [EXP_W-1:0]        i_exp;
    logic [MANT_W-1:0]       i_mant;
    logic                    i_carry;
    logic                    o_valid;
    logic                    i_out_ready;
    logic [EXP_W+MANT_W-1:0] o_result;
    logic [CNT_W-1:0]        o_shifts;
    logic                    o_overflow;
    logic                    o_underflow;
    logic                    o_zero;

    modport slave (
        input  i_valid, i_sign, i_exp, i_mant, i_carry, i_out_ready,
        output o_in_ready, o_valid, o_result, o_shifts,
        output o_overflow, o_underflow, o_zero
    );

    modport master (
        output i_valid, i_sign, i_exp, i_mant, i_carry, i_out_ready,
        input  o_in_ready, o_valid, o_result, o_shifts,
        input  o_overflow, o_underflow, o_zero
    );
endinterface

// File: rtl/float_normalizer.sv
// Normalizes the adder's raw magnitude (one right shift on carry, or one left
// shift per cycle) and packs a single-precision word with overflow/underflow flags.
module float_normalizer
    import float_normalizer_pkg::*;
#(
    parameter int EXP_W  = FP_EXP_W,
    parameter int MANT_W = FP_MANT_W,
    parameter int CNT_W  = FP_CNT_W
) (
    input logic          i_clk,
    input logic          i_rst,
    float_normalizer_if.slave bus
);

    state_t              state;
    logic                sign_r;
    logic [EXP_W-1:0]    exp_r;
    logic [MANT_W-1:0]   mant_r;
    logic                carry_r;
    logic [CNT_W-1:0]    cnt_r;

    logic [EXP_W-1:0]        exp_inc;
    logic [MANT_W-1:0]       mant_rsh;
    logic                    fin;
    logic [EXP_W+MANT_W-1:0] res_n;
    logic                    ovf_n;
    logic                    unf_n;
    logic                    zero_n;

    assign exp_inc  = exp_r + 1'b1;
    assign mant_rsh = {1'b1, mant_r[MANT_W-1:1]};

    // Ready is combinational on the downstream ready so DONE can hand off and
    // accept in the same cycle; it is held low while reset is asserted.
    assign bus.o_in_ready = !i_rst && ((state == IDLE) ||
                                       (state == DONE && bus.i_out_ready));

    always_comb begin
        fin    = 1'b1;
        res_n  = pack(sign_r, exp_r, mant_r);
        ovf_n  = 1'b0;
        unf_n  = 1'b0;
        zero_n = 1'b0;
        if (exp_r == EXP_MAX) begin
            res_n = pack(sign_r, exp_r, mant_r);
        end else if (carry_r) begin
            if (exp_inc == EXP_MAX) begin
                res_n = pack(sign_r, EXP_MAX, '0);
                ovf_n = 1'b1;
            end else begin
                res_n = pack(sign_r, exp_inc, mant_rsh);
            end
        end else if (mant_r == '0) begin
            res_n  = pack(sign_r, '0, '0);
            zero_n = 1'b1;
        end else if (mant_r[MANT_W-1]) begin
            res_n = pack(sign_r, exp_r, mant_r);
        end else if (exp_r <= EXP_W'(1)) begin
            res_n  = pack(sign_r, '0, '0);
            unf_n  = 1'b1;
            zero_n = 1'b1;
        end else begin
            fin = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state           <= IDLE;
            bus.o_valid     <= 1'b0;
            bus.o_result    <= '0;
            bus.o_shifts    <= '0;
            bus.o_overflow  <= 1'b0;
            bus.o_underflow <= 1'b0;
            bus.o_zero      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.i_valid) begin
                        sign_r  <= bus.i_sign;
                        exp_r   <= bus.i_exp;
                        mant_r  <= bus.i_mant;
                        carry_r <= bus.i_carry;
                        cnt_r   <= '0;
                        state   <= NORM;
                    end
                end
                NORM: begin
                    if (fin) begin
                        bus.o_result    <= res_n;
                        bus.o_shifts    <= cnt_r;
                        bus.o_overflow  <= ovf_n;
                        bus.o_underflow <= unf_n;
                        bus.o_zero      <= zero_n;
                        bus.o_valid     <= 1'b1;
                        state           <= DONE;
                    end else begin
                        mant_r <= mant_r << 1;
                        exp_r  <= exp_r - 1'b1;
                        cnt_r  <= cnt_r + 1'b1;
                    end
                end
                DONE: begin
                    // Result and flags stay frozen until the consumer takes them.
                    if (bus.i_out_ready) begin
                        bus.o_valid <= 1'b0;
                        if (bus.i_valid) begin
                            sign_r  <= bus.i_sign;
                            exp_r   <= bus.i_exp;
                            mant_r  <= bus.i_mant;
                            carry_r <= bus.i_carry;
                            cnt_r   <= '0;
                            state   <= NORM;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_float_normalizer.sv
// Self-checking bench for float_normalizer: directed cases plus randomized
// operands checked against a leading-zero-count reference model.
module tb_float_normalizer;
    import float_normalizer_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    float_normalizer_if #(.EXP_W(8), .MANT_W(24), .CNT_W(5)) bif ();

    float_normalizer #(.EXP_W(8), .MANT_W(24), .CNT_W(5)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bif.slave)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
        end
    endtask

    // Reference: count leading zeros, then decide whether the exponent can
    // absorb that many shifts before reaching 1.
    task automatic model(input logic s, input logic [7:0] e, input logic [23:0] m,
                         input logic c, output logic [31:0] r, output int k,
                         output logic ov, output logic un, output logic z);
        int lz;
        int ei;
        logic [23:0] mn;
        r = 32'h0; k = 0; ov = 1'b0; un = 1'b0; z = 1'b0;
        ei = int'(e);
        if (e == 8'hFF) begin
            r = {s, e, m[22:0]};
        end else if (c) begin
            if (ei + 1 == 255) begin
                r  = {s, 8'hFF, 23'h0};
                ov = 1'b1;
            end else begin
                mn = m >> 1;
                r  = {s, 8'(ei + 1), mn[22:0]};
            end
        end else if (m == 24'h0) begin
            r = {s, 31'h0};
            z = 1'b1;
        end else begin
            lz = 0;
            while (m[23 - lz] == 1'b0) lz++;
            if (lz == 0 || ei - lz >= 1) begin
                mn = m << lz;
                k  = lz;
                r  = {s, 8'(ei - lz), mn[22:0]};
            end else begin
                k  = (ei >= 2) ? ei - 1 : 0;
                r  = {s, 31'h0};
                un = 1'b1;
                z  = 1'b1;
            end
        end
    endtask

    task automatic accept_op(input logic s, input logic [7:0] e, input logic [23:0] m, input logic c);
        bif.i_valid = 1'b1;
        bif.i_sign  = s;
        bif.i_exp   = e;
        bif.i_mant  = m;
        bif.i_carry = c;
        #1;
        chk("in_ready_accept", 32'(bif.o_in_ready), 32'd1);
        @(posedge clk);
        #1;
        bif.i_valid = 1'b0;
        bif.i_out_ready = 1'b0;
    endtask

    task automatic await_result(input logic [31:0] er, input int ek,
                                input logic ov, input logic un, input logic z);
        int lat;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!bif.o_valid && lat < 40);
        chk("latency", 32'(lat + 1), 32'(ek + 2));
        chk("result", bif.o_result, er);
        chk("shifts", 32'(bif.o_shifts), 32'(ek));
        chk("flags", {29'h0, bif.o_overflow, bif.o_underflow, bif.o_zero}, {29'h0, ov, un, z});
    endtask

    task automatic hold_result(input int hold, input logic [31:0] er);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk("hold_result", bif.o_result, er);
            chk("hold_valid", 32'(bif.o_valid), 32'd1);
            chk("hold_in_ready", 32'(bif.o_in_ready), 32'd0);
        end
    endtask

    task automatic release_result();
        bif.i_out_ready = 1'b1;
        @(posedge clk);
        #1;
        bif.i_out_ready = 1'b0;
        chk("valid_after_handoff", 32'(bif.o_valid), 32'd0);
    endtask

    task automatic run_vec(input logic s, input logic [7:0] e, input logic [23:0] m, input logic c,
                           input int hold, input logic [31:0] er, input int ek,
                           input logic ov, input logic un, input logic z);
        accept_op(s, e, m, c);
        await_result(er, ek, ov, un, z);
        hold_result(hold, er);
        release_result();
    endtask

    initial begin
        logic [31:0] r;
        int          k;
        logic        ov, un, z;
        logic        s, c;
        logic [7:0]  e;
        logic [23:0] m;

        bif.i_valid = 1'b0;
        bif.i_sign = 1'b0;
        bif.i_exp = 8'h0;
        bif.i_mant = 24'h0;
        bif.i_carry = 1'b0;
        bif.i_out_ready = 1'b0;

        @(posedge clk);
        #1;
        chk("rst_valid", 32'(bif.o_valid), 32'd0);
        chk("rst_in_ready", 32'(bif.o_in_ready), 32'd0);
        chk("rst_result", bif.o_result, 32'h0);
        chk("rst_shifts", 32'(bif.o_shifts), 32'd0);
        chk("rst_flags", {29'h0, bif.o_overflow, bif.o_underflow, bif.o_zero}, 32'h0);
        rst = 1'b0;
        #1;
        chk("idle_in_ready", 32'(bif.o_in_ready), 32'd1);

        run_vec(1'b0, 8'(BIAS + 1), 24'hC00000, 1'b0, 0, 32'h40400000, 0, 1'b0, 1'b0, 1'b0);
        run_vec(1'b0, 8'h7F, 24'h800000, 1'b1, 0, 32'h40400000, 0, 1'b0, 1'b0, 1'b0);
        run_vec(1'b1, 8'h85, 24'h000300, 1'b0, 0, 32'hBBC00000, 14, 1'b0, 1'b0, 1'b0);
        run_vec(1'b0, 8'h90, 24'h000000, 1'b0, 0, 32'h00000000, 0, 1'b0, 1'b0, 1'b1);
        run_vec(1'b1, 8'h90, 24'h000000, 1'b0, 0, 32'h80000000, 0, 1'b0, 1'b0, 1'b1);
        run_vec(1'b0, 8'h02, 24'h000001, 1'b0, 0, 32'h00000000, 1, 1'b0, 1'b1, 1'b1);
        run_vec(1'b0, 8'hFE, 24'h800000, 1'b1, 0, 32'h7F800000, 0, 1'b1, 1'b0, 1'b0);
        run_vec(1'b0, 8'hFF, 24'hC00001, 1'b1, 0, 32'h7FC00001, 0, 1'b0, 1'b0, 1'b0);
        run_vec(1'b0, 8'h80, 24'h000001, 1'b0, 0, 32'h34800000, 23, 1'b0, 1'b0, 1'b0);

        // Reset asserted mid-normalization must abandon the operand.
        accept_op(1'b0, 8'h80, 24'h000001, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_mid_in_ready", 32'(bif.o_in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_mid_valid", 32'(bif.o_valid), 32'd0);
        chk("rst_mid_idle", 32'(bif.o_in_ready), 32'd1);
        repeat (25) @(posedge clk);
        #1;
        chk("rst_mid_no_result", 32'(bif.o_valid), 32'd0);

        // Backpressure, then handoff with a back-to-back accept.
        accept_op(1'b1, 8'h85, 24'h000300, 1'b0);
        await_result(32'hBBC00000, 14, 1'b0, 1'b0, 1'b0);
        hold_result(5, 32'hBBC00000);
        bif.i_valid = 1'b1;
        bif.i_sign = 1'b0;
        bif.i_exp = 8'h81;
        bif.i_mant = 24'h400000;
        bif.i_carry = 1'b0;
        bif.i_out_ready = 1'b1;
        #1;
        chk("b2b_in_ready", 32'(bif.o_in_ready), 32'd1);
        @(posedge clk);
        #1;
        bif.i_valid = 1'b0;
        bif.i_out_ready = 1'b0;
        chk("b2b_valid_drop", 32'(bif.o_valid), 32'd0);
        await_result(32'h40000000, 1, 1'b0, 1'b0, 1'b0);
        release_result();

        for (int n = 0; n < 250; n++) begin
            s = 1'($urandom());
            c = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 5))
                0: e = 8'hFF;
                1: e = 8'hFE;
                2: e = 8'($urandom_range(0, 3));
                3: e = 8'($urandom_range(4, 24));
                default: e = 8'($urandom());
            endcase
            m = 24'($urandom()) >> $urandom_range(0, 24);
            model(s, e, m, c, r, k, ov, un, z);
            run_vec(s, e, m, c, $urandom_range(0, 2), r, k, ov, un, z);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
